// File: rtl/sal_bk_ctrl.sv
// sal_bk_ctrl -- per-bank DDR2 controller, request side of the bank/scheduler
// handshake. It owns one bank's state machine and its timing counters, and
// raises act/rd/wr/pre/ref requests toward the scheduler. The bank advances
// only when the scheduler grants the request that is currently raised. The
// page policy is open-page: a row stays open until a row miss or a refresh
// forces a precharge.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready        single-entry upstream access buffer handshake
//   req_wr, req_row            access type (1=write) and target row
//   ref_req_i / ref_ack_o      refresh request in; one-cycle pulse when REF is granted
//   act_req, rd_req, wr_req,
//   pre_req, ref_req           command requests (registered, at most one high)
//   ra                         row for ACT, valid together with act_req
//   act_gnt .. ref_gnt         scheduler grants (ignored unless matching req is high)
//   bank_open, open_row        open-row status
module sal_bk_ctrl #(
    parameter int ROW_AW = 14,
    parameter int T_RCD  = 3,
    parameter int T_RP   = 3,
    parameter int T_RAS  = 8,
    parameter int T_RTP  = 2,
    parameter int T_WTP  = 8,
    parameter int T_RFC  = 26
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ROW_AW-1:0] req_row,
    input  logic              ref_req_i,
    output logic              ref_ack_o,
    output logic              act_req,
    output logic              rd_req,
    output logic              wr_req,
    output logic              pre_req,
    output logic              ref_req,
    output logic [ROW_AW-1:0] ra,
    input  logic              act_gnt,
    input  logic              rd_gnt,
    input  logic              wr_gnt,
    input  logic              pre_gnt,
    input  logic              ref_gnt,
    output logic              bank_open,
    output logic [ROW_AW-1:0] open_row
);

    // One counter width shared by all timers, sized for the largest parameter.
    localparam int M_A  = (T_RCD > T_RP)  ? T_RCD : T_RP;
    localparam int M_B  = (T_RAS > T_RTP) ? T_RAS : T_RTP;
    localparam int M_C  = (T_WTP > T_RFC) ? T_WTP : T_RFC;
    localparam int M_AB = (M_A > M_B) ? M_A : M_B;
    localparam int MAXT = (M_AB > M_C) ? M_AB : M_C;
    localparam int CW   = $clog2(MAXT + 1);

    // Counters are loaded with T-1 so that, with requests decoded from the
    // registered state, the dependent request first appears exactly T cycles
    // after the grant cycle.
    localparam logic [CW-1:0] LD_RCD = CW'(T_RCD - 1);
    localparam logic [CW-1:0] LD_RP  = CW'(T_RP - 1);
    localparam logic [CW-1:0] LD_RAS = CW'(T_RAS - 1);
    localparam logic [CW-1:0] LD_RTP = CW'(T_RTP - 1);
    localparam logic [CW-1:0] LD_WTP = CW'(T_WTP - 1);
    localparam logic [CW-1:0] LD_RFC = CW'(T_RFC - 1);

    // Bit positions inside the request vector.
    localparam int I_ACT = 4;
    localparam int I_RD  = 3;
    localparam int I_WR  = 2;
    localparam int I_PRE = 1;
    localparam int I_REF = 0;

    typedef enum logic [2:0] {
        S_CLOSED,
        S_ACTIVATING,
        S_OPEN,
        S_PRECHARGING,
        S_REFRESHING
    } state_t;

    state_t              state_q, state_next;
    logic [CW-1:0]       cnt_main_q, cnt_main_next;
    logic [CW-1:0]       cnt_ras_q, cnt_ras_next;
    logic [CW-1:0]       cnt_col_q, cnt_col_next;
    logic                pend_q, pend_next;
    logic                pend_wr_q, pend_wr_next;
    logic [ROW_AW-1:0]   pend_row_q, pend_row_next;
    logic                ref_pend_q, ref_pend_next;
    logic [ROW_AW-1:0]   open_row_q, open_row_next;
    logic                bank_open_q, bank_open_next;
    logic [4:0]          req_q, req_next;
    logic [ROW_AW-1:0]   ra_q, ra_next;
    logic                ref_ack_q, ref_ack_next;
    logic                req_ready_q, req_ready_next;

    logic [4:0]          gnt_vec;
    logic [4:0]          fire;
    logic [4:0]          fresh;
    logic                accept;
    logic [CW-1:0]       main_dec, ras_dec, col_dec;
    logic                timers_clear;
    logic                row_hit;

    function automatic logic [CW-1:0] sat_dec(input logic [CW-1:0] v);
        return (v == '0) ? '0 : v - 1'b1;
    endfunction

    assign gnt_vec = {act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt};

    // A grant counts only while its own request is raised.
    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_fire
            assign fire[gi] = req_q[gi] & gnt_vec[gi];
        end
    endgenerate

    always_comb begin
        state_next     = state_q;
        open_row_next  = open_row_q;
        bank_open_next = bank_open_q;
        fresh          = 5'b00000;
        ra_next        = ra_q;
        timers_clear   = 1'b0;
        row_hit        = 1'b0;

        accept = req_valid & req_ready_q;

        // Upstream buffer: acceptance only happens while empty, so it never
        // coincides with the column grant that empties it.
        pend_next     = accept | (pend_q & ~(fire[I_RD] | fire[I_WR]));
        pend_wr_next  = accept ? req_wr  : pend_wr_q;
        pend_row_next = accept ? req_row : pend_row_q;

        // A refresh pulse arriving while one is pending merges into it; a
        // pulse coinciding with the grant starts a fresh pending refresh.
        ref_pend_next = (ref_pend_q & ~fire[I_REF]) | ref_req_i;

        main_dec = sat_dec(cnt_main_q);
        ras_dec  = sat_dec(cnt_ras_q);
        col_dec  = sat_dec(cnt_col_q);

        if (fire[I_ACT])      cnt_main_next = LD_RCD;
        else if (fire[I_PRE]) cnt_main_next = LD_RP;
        else if (fire[I_REF]) cnt_main_next = LD_RFC;
        else                  cnt_main_next = main_dec;

        cnt_ras_next = fire[I_ACT] ? LD_RAS : ras_dec;

        // Column-to-precharge window: a new column command only extends it.
        if (fire[I_RD])      cnt_col_next = (LD_RTP > col_dec) ? LD_RTP : col_dec;
        else if (fire[I_WR]) cnt_col_next = (LD_WTP > col_dec) ? LD_WTP : col_dec;
        else                 cnt_col_next = col_dec;

        // Timed states leave one cycle before their counter reaches zero so
        // the follow-on request lines up with the counter expiring.
        case (state_q)
            S_CLOSED: begin
                if (fire[I_ACT]) begin
                    open_row_next = pend_row_q;
                    if (T_RCD == 1) begin
                        state_next     = S_OPEN;
                        bank_open_next = 1'b1;
                    end else begin
                        state_next = S_ACTIVATING;
                    end
                end else if (fire[I_REF]) begin
                    state_next = (T_RFC == 1) ? S_CLOSED : S_REFRESHING;
                end
            end
            S_ACTIVATING: begin
                if (cnt_main_q <= 1) begin
                    state_next     = S_OPEN;
                    bank_open_next = 1'b1;
                end
            end
            S_OPEN: begin
                if (fire[I_PRE]) begin
                    bank_open_next = 1'b0;
                    state_next     = (T_RP == 1) ? S_CLOSED : S_PRECHARGING;
                end
            end
            S_PRECHARGING: begin
                if (cnt_main_q <= 1) state_next = S_CLOSED;
            end
            S_REFRESHING: begin
                if (cnt_main_q <= 1) state_next = S_CLOSED;
            end
            default: state_next = S_CLOSED;
        endcase

        // Request decode from the next registered values; the result is
        // registered, so grants never reach the request outputs combinationally.
        timers_clear = (cnt_ras_next == '0) && (cnt_col_next == '0);
        row_hit      = (pend_row_next == open_row_next);
        case (state_next)
            S_CLOSED: begin
                if (ref_pend_next)  fresh[I_REF] = 1'b1;
                else if (pend_next) fresh[I_ACT] = 1'b1;
            end
            S_OPEN: begin
                if (ref_pend_next) begin
                    fresh[I_PRE] = timers_clear;
                end else if (pend_next && row_hit) begin
                    fresh[I_WR] = pend_wr_next;
                    fresh[I_RD] = ~pend_wr_next;
                end else if (pend_next) begin
                    fresh[I_PRE] = timers_clear;
                end
            end
            default: fresh = 5'b00000;
        endcase

        // A raised request stays until granted; this is what lets a column
        // command granted alongside a new refresh pulse complete first.
        if (|(req_q & ~gnt_vec)) begin
            req_next = req_q;
        end else begin
            req_next = fresh;
            if (fresh[I_ACT]) ra_next = pend_row_next;
        end

        ref_ack_next   = fire[I_REF];
        req_ready_next = ~pend_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_CLOSED;
            cnt_main_q  <= '0;
            cnt_ras_q   <= '0;
            cnt_col_q   <= '0;
            pend_q      <= 1'b0;
            pend_wr_q   <= 1'b0;
            pend_row_q  <= '0;
            ref_pend_q  <= 1'b0;
            open_row_q  <= '0;
            bank_open_q <= 1'b0;
            req_q       <= 5'b00000;
            ra_q        <= '0;
            ref_ack_q   <= 1'b0;
            req_ready_q <= 1'b1;
        end else begin
            state_q     <= state_next;
            cnt_main_q  <= cnt_main_next;
            cnt_ras_q   <= cnt_ras_next;
            cnt_col_q   <= cnt_col_next;
            pend_q      <= pend_next;
            pend_wr_q   <= pend_wr_next;
            pend_row_q  <= pend_row_next;
            ref_pend_q  <= ref_pend_next;
            open_row_q  <= open_row_next;
            bank_open_q <= bank_open_next;
            req_q       <= req_next;
            ra_q        <= ra_next;
            ref_ack_q   <= ref_ack_next;
            req_ready_q <= req_ready_next;
        end
    end

    assign act_req   = req_q[I_ACT];
    assign rd_req    = req_q[I_RD];
    assign wr_req    = req_q[I_WR];
    assign pre_req   = req_q[I_PRE];
    assign ref_req   = req_q[I_REF];
    assign ra        = ra_q;
    assign ref_ack_o = ref_ack_q;
    assign req_ready = req_ready_q;
    assign bank_open = bank_open_q;
    assign open_row  = open_row_q;

endmodule

// File: tb/tb_sal_bk_ctrl.sv
// Directed bench for sal_bk_ctrl: walks a closed-bank read, a row-hit
// stream, row misses gated by tRAS and by write recovery, a refresh with a
// pending hit, withheld grants, and reset during activation.
module tb_sal_bk_ctrl;

    localparam logic [4:0] V_NONE = 5'b00000;
    localparam logic [4:0] V_ACT  = 5'b10000;
    localparam logic [4:0] V_RD   = 5'b01000;
    localparam logic [4:0] V_WR   = 5'b00100;
    localparam logic [4:0] V_PRE  = 5'b00010;
    localparam logic [4:0] V_REF  = 5'b00001;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_wr;
    logic [13:0] req_row;
    logic        ref_req_i, ref_ack_o;
    logic        act_req, rd_req, wr_req, pre_req, ref_req;
    logic [13:0] ra, open_row;
    logic        act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt;
    logic        bank_open;

    logic        gnt_en;
    logic [4:0]  frc_gnt;
    logic [4:0]  rq;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign rq = {act_req, rd_req, wr_req, pre_req, ref_req};

    // Immediate grants when enabled, plus forced grants for the ignore test.
    always_comb begin
        {act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt} = (rq & {5{gnt_en}}) | frc_gnt;
    end

    sal_bk_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wr    (req_wr),
        .req_row   (req_row),
        .ref_req_i (ref_req_i),
        .ref_ack_o (ref_ack_o),
        .act_req   (act_req),
        .rd_req    (rd_req),
        .wr_req    (wr_req),
        .pre_req   (pre_req),
        .ref_req   (ref_req),
        .ra        (ra),
        .act_gnt   (act_gnt),
        .rd_gnt    (rd_gnt),
        .wr_gnt    (wr_gnt),
        .pre_gnt   (pre_gnt),
        .ref_gnt   (ref_gnt),
        .bank_open (bank_open),
        .open_row  (open_row)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one access: valid for one cycle, leaves the bench in the cycle after.
    task automatic issue(input logic wr, input logic [13:0] row);
        $display("txn cycle %0d: %s row 0x%0h", cyc, wr ? "write" : "read", row);
        req_valid = 1'b1;
        req_wr    = wr;
        req_row   = row;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_vec(input string tag, input logic [4:0] want, input int budget, output int at);
        int n = 0;
        while (rq != want && n < budget) begin
            tick();
            n++;
        end
        if (rq != want) chk({tag, " timeout"}, 32'(rq), 32'(want));
        at = cyc;
    endtask

    initial begin
        int t0, p, a, r, w, at;

        rst_n = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_row = '0;
        ref_req_i = 1'b0; gnt_en = 1'b0; frc_gnt = 5'b00000;
        tick(); tick();
        chk("rst reqs", 32'(rq), 32'(V_NONE));
        chk("rst req_ready", 32'(req_ready), 1);
        chk("rst bank_open", 32'(bank_open), 0);
        chk("rst open_row", 32'(open_row), 0);
        chk("rst ra", 32'(ra), 0);
        chk("rst ref_ack", 32'(ref_ack_o), 0);
        rst_n = 1'b1;
        tick();

        // Grants without a raised request are ignored.
        frc_gnt = 5'b11111;
        tick();
        frc_gnt = 5'b00000;
        tick();
        chk("stray gnt reqs", 32'(rq), 32'(V_NONE));
        chk("stray gnt bank_open", 32'(bank_open), 0);
        chk("stray gnt req_ready", 32'(req_ready), 1);

        // 1. Closed bank read of row 0x12 with immediate grants.
        gnt_en = 1'b1;
        t0 = cyc;
        issue(1'b0, 14'h12);
        chk("t1 act at +1", 32'(rq), 32'(V_ACT));
        chk("t1 ra", 32'(ra), 32'h12);
        chk("t1 req_ready low", 32'(req_ready), 0);
        tick();
        chk("t1 activating", 32'(rq), 32'(V_NONE));
        tick();
        chk("t1 activating", 32'(rq), 32'(V_NONE));
        tick();
        chk("t1 rd at +4", 32'(rq), 32'(V_RD));
        chk("t1 rd cycle", 32'(cyc - t0), 4);
        chk("t1 bank_open", 32'(bank_open), 1);
        chk("t1 open_row", 32'(open_row), 32'h12);
        tick();
        chk("t1 req_ready at +5", 32'(req_ready), 1);
        chk("t1 idle", 32'(rq), 32'(V_NONE));

        // 2. Row-hit stream: one RD per access, no ACT/PRE.
        for (int i = 0; i < 4; i++) begin
            issue(1'b0, 14'h12);
            chk("t2 hit rd", 32'(rq), 32'(V_RD));
            tick();
            chk("t2 idle", 32'(rq), 32'(V_NONE));
            chk("t2 req_ready", 32'(req_ready), 1);
            chk("t2 bank_open", 32'(bank_open), 1);
        end

        // 3. Row misses: PRE then ACT at pre_gnt+3; next miss waits on tRAS.
        issue(1'b0, 14'h34);
        wait_vec("t3 pre", V_PRE, 10, p);
        tick();
        wait_vec("t3 act", V_ACT, 10, a);
        chk("t3 act at pre+3", 32'(a - p), 3);
        chk("t3 ra", 32'(ra), 32'h34);
        chk("t3 closed", 32'(bank_open), 0);
        tick();
        wait_vec("t3 rd", V_RD, 10, r);
        chk("t3 rd at act+3", 32'(r - a), 3);
        chk("t3 open_row", 32'(open_row), 32'h34);
        tick();
        issue(1'b0, 14'h56);
        chk("t3 tRAS hold", 32'(rq), 32'(V_NONE));
        wait_vec("t3 pre2", V_PRE, 20, p);
        chk("t3 pre at act+8", 32'(p - a), 8);
        tick();
        wait_vec("t3 act2", V_ACT, 10, a);
        chk("t3 ra2", 32'(ra), 32'h56);
        tick();
        wait_vec("t3 rd2", V_RD, 10, r);
        tick();

        // 4. Write then miss: precharge gated by write recovery, not tRAS.
        for (int i = 0; i < 10; i++) tick();
        issue(1'b1, 14'h56);
        chk("t4 wr", 32'(rq), 32'(V_WR));
        w = cyc;
        tick();
        chk("t4 req_ready", 32'(req_ready), 1);
        issue(1'b0, 14'h78);
        chk("t4 wtp hold", 32'(rq), 32'(V_NONE));
        wait_vec("t4 pre", V_PRE, 20, p);
        chk("t4 pre at wr+8", 32'(p - w), 8);
        tick();
        wait_vec("t4 act", V_ACT, 10, a);
        chk("t4 ra", 32'(ra), 32'h78);
        tick();
        wait_vec("t4 rd", V_RD, 10, r);
        tick();

        // 5. Refresh with open row and a pending hit.
        for (int i = 0; i < 10; i++) tick();
        $display("txn cycle %0d: refresh + read row 0x78", cyc);
        ref_req_i = 1'b1;
        issue(1'b0, 14'h78);
        ref_req_i = 1'b0;
        chk("t5 pre for ref", 32'(rq), 32'(V_PRE));
        p = cyc;
        tick();
        wait_vec("t5 ref", V_REF, 10, r);
        chk("t5 ref at pre+3", 32'(r - p), 3);
        chk("t5 closed", 32'(bank_open), 0);
        tick();
        chk("t5 ref_ack pulse", 32'(ref_ack_o), 1);
        tick();
        chk("t5 ref_ack end", 32'(ref_ack_o), 0);
        wait_vec("t5 act", V_ACT, 40, a);
        chk("t5 act at ref+26", 32'(a - r), 26);
        chk("t5 ra", 32'(ra), 32'h78);
        tick();
        wait_vec("t5 rd", V_RD, 10, at);
        chk("t5 rd at act+3", 32'(at - a), 3);
        tick();

        // 6. Withheld grants hold the request; reset during ACTIVATING.
        gnt_en = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        issue(1'b0, 14'h9a);
        wait_vec("t6 pre", V_PRE, 10, p);
        for (int i = 0; i < 10; i++) begin
            chk("t6 pre held", 32'(rq), 32'(V_PRE));
            chk("t6 still open", 32'(bank_open), 1);
            tick();
        end
        gnt_en = 1'b1;
        tick();
        gnt_en = 1'b0;
        wait_vec("t6 act", V_ACT, 10, a);
        for (int i = 0; i < 10; i++) begin
            chk("t6 act held", 32'(rq), 32'(V_ACT));
            chk("t6 ra held", 32'(ra), 32'h9a);
            tick();
        end
        gnt_en = 1'b1;
        tick();
        gnt_en = 1'b0;
        chk("t6 activating", 32'(rq), 32'(V_NONE));
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6 rst reqs", 32'(rq), 32'(V_NONE));
        chk("t6 rst req_ready", 32'(req_ready), 1);
        chk("t6 rst bank_open", 32'(bank_open), 0);
        chk("t6 rst open_row", 32'(open_row), 0);
        chk("t6 rst ra", 32'(ra), 0);
        tick();
        rst_n = 1'b1;
        gnt_en = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("t6 post rst idle", 32'(rq), 32'(V_NONE));
        chk("t6 post rst bank_open", 32'(bank_open), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish by 100000");
        $fatal(1);
    end

endmodule
